// File: rtl/cpu6502_dma_arbiter_pkg.sv
// Shared types and default addresses for the 6502 bus arbiter and its page-copy DMA engine.
// The DMA trigger register and the destination port default to the NES OAM DMA locations.
package cpu6502_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    HALT  = 3'd1,
    ALIGN = 3'd2,
    READ  = 3'd3,
    WRITE = 3'd4
  } dma_state_t;

  localparam logic [15:0] DEF_DMA_REG_ADDR = 16'h4014;
  localparam logic [15:0] DEF_DST_ADDR     = 16'h2004;

endpackage

// File: rtl/cpu6502_dma_arbiter.sv
// Muxes the 6502 bus between CPU and a page-copy DMA; IDLE pass-through has zero latency.
// The CPU is held via cpu_rdy for 1+2*LEN or 2+2*LEN cycles (odd-cycle alignment) per transfer.
module cpu6502_dma_arbiter
  import cpu6502_pkg::*;
#(
  parameter logic [15:0] DMA_REG_ADDR = DEF_DMA_REG_ADDR,
  parameter logic [15:0] DST_ADDR     = DEF_DST_ADDR,
  parameter int unsigned LEN          = 256
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_wdata,
  input  logic        cpu_we,
  output logic [7:0]  cpu_rdata,
  output logic        cpu_rdy,
  output logic [15:0] mem_addr,
  output logic [7:0]  mem_wdata,
  output logic        mem_we,
  input  logic [7:0]  mem_rdata,
  output logic        dma_busy,
  output logic        dma_done
);

  localparam int unsigned      IDX_W    = (LEN > 1) ? $clog2(LEN) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(LEN - 1);

  dma_state_t r_state;
  dma_state_t w_state_nxt;
  logic [7:0] r_idx;
  logic [7:0] r_page;
  logic [7:0] r_latch;
  logic       r_cyc_odd;
  logic       w_trigger;
  logic       w_last;

  assign w_trigger = cpu_we && (cpu_addr == DMA_REG_ADDR);
  assign w_last    = (r_idx[IDX_W-1:0] == IDX_LAST);
  assign dma_busy  = (r_state != IDLE);
  assign cpu_rdata = mem_rdata;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_state   <= IDLE;
      r_idx     <= 8'd0;
      r_page    <= 8'd0;
      r_latch   <= 8'd0;
      r_cyc_odd <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cyc_odd <= ~r_cyc_odd;
      case (r_state)
        IDLE: begin
          if (w_trigger) begin
            r_page <= cpu_wdata;
            r_idx  <= 8'd0;
          end
        end
        READ:    r_latch <= mem_rdata;
        WRITE:   r_idx   <= w_last ? 8'd0 : r_idx + 8'd1;
        default: ;
      endcase
    end
  end

  // Outside IDLE the CPU bus is held, so its write strobe and address never reach memory.
  always_comb begin
    w_state_nxt = r_state;
    mem_addr    = cpu_addr;
    mem_wdata   = cpu_wdata;
    mem_we      = 1'b0;
    cpu_rdy     = 1'b0;
    dma_done    = 1'b0;
    case (r_state)
      IDLE: begin
        cpu_rdy = 1'b1;
        mem_we  = cpu_we && !w_trigger;
        if (w_trigger) w_state_nxt = HALT;
      end
      HALT:  w_state_nxt = r_cyc_odd ? ALIGN : READ;
      ALIGN: w_state_nxt = READ;
      READ: begin
        mem_addr    = {r_page, r_idx};
        w_state_nxt = WRITE;
      end
      WRITE: begin
        mem_addr  = DST_ADDR;
        mem_wdata = r_latch;
        mem_we    = 1'b1;
        if (w_last) begin
          dma_done    = 1'b1;
          w_state_nxt = IDLE;
        end else begin
          w_state_nxt = READ;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_cpu6502_dma_arbiter.sv
// Bench for cpu6502_dma_arbiter: a LEN=256 and a LEN=16 instance share one memory model;
// the bus schedule of each transfer is predicted from cycle parity and the per-byte read/write pairing.
module tb_cpu6502_dma_arbiter;

  localparam logic [15:0] REG = 16'h4014;
  localparam logic [15:0] DST = 16'h2004;

  logic CLK = 1'b0;
  logic RESET = 1'b1;
  always #5 CLK = ~CLK;

  // sel routes the bench CPU bus to one instance; the other sees an idle bus.
  logic        sel = 1'b0;
  logic [15:0] cpu_addr = 16'h0;
  logic [7:0]  cpu_wdata = 8'h0;
  logic        cpu_we = 1'b0;

  logic [15:0] a_cpu_addr, b_cpu_addr, a_mem_addr, b_mem_addr;
  logic [7:0]  a_cpu_wdata, b_cpu_wdata, a_cpu_rdata, b_cpu_rdata;
  logic [7:0]  a_mem_wdata, b_mem_wdata, a_mem_rdata, b_mem_rdata;
  logic        a_cpu_we, b_cpu_we, a_cpu_rdy, b_cpu_rdy, a_mem_we, b_mem_we;
  logic        a_dma_busy, b_dma_busy, a_dma_done, b_dma_done;

  assign a_cpu_addr  = sel ? 16'h0 : cpu_addr;
  assign a_cpu_wdata = sel ? 8'h0  : cpu_wdata;
  assign a_cpu_we    = sel ? 1'b0  : cpu_we;
  assign b_cpu_addr  = sel ? cpu_addr  : 16'h0;
  assign b_cpu_wdata = sel ? cpu_wdata : 8'h0;
  assign b_cpu_we    = sel ? cpu_we    : 1'b0;

  logic [15:0] o_mem_addr;
  logic [7:0]  o_mem_wdata, o_cpu_rdata;
  logic        o_mem_we, o_cpu_rdy, o_dma_busy, o_dma_done;
  assign o_mem_addr  = sel ? b_mem_addr  : a_mem_addr;
  assign o_mem_wdata = sel ? b_mem_wdata : a_mem_wdata;
  assign o_mem_we    = sel ? b_mem_we    : a_mem_we;
  assign o_cpu_rdata = sel ? b_cpu_rdata : a_cpu_rdata;
  assign o_cpu_rdy   = sel ? b_cpu_rdy   : a_cpu_rdy;
  assign o_dma_busy  = sel ? b_dma_busy  : a_dma_busy;
  assign o_dma_done  = sel ? b_dma_done  : a_dma_done;

  cpu6502_dma_arbiter #(.LEN(256)) dut_a (
    .CLK(CLK), .RESET(RESET),
    .cpu_addr(a_cpu_addr), .cpu_wdata(a_cpu_wdata), .cpu_we(a_cpu_we),
    .cpu_rdata(a_cpu_rdata), .cpu_rdy(a_cpu_rdy),
    .mem_addr(a_mem_addr), .mem_wdata(a_mem_wdata), .mem_we(a_mem_we),
    .mem_rdata(a_mem_rdata), .dma_busy(a_dma_busy), .dma_done(a_dma_done)
  );

  cpu6502_dma_arbiter #(.LEN(16)) dut_b (
    .CLK(CLK), .RESET(RESET),
    .cpu_addr(b_cpu_addr), .cpu_wdata(b_cpu_wdata), .cpu_we(b_cpu_we),
    .cpu_rdata(b_cpu_rdata), .cpu_rdy(b_cpu_rdy),
    .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata), .mem_we(b_mem_we),
    .mem_rdata(b_mem_rdata), .dma_busy(b_dma_busy), .dma_done(b_dma_done)
  );

  // Flat 64 KiB memory with combinational reads; pl_* is a bench-only preload port.
  logic [7:0]  mem [0:65535];
  logic        pl_we = 1'b0;
  logic [15:0] pl_addr = 16'h0;
  logic [7:0]  pl_dat = 8'h0;
  assign a_mem_rdata = mem[a_mem_addr];
  assign b_mem_rdata = mem[b_mem_addr];
  always @(posedge CLK) begin
    if (a_mem_we) mem[a_mem_addr] <= a_mem_wdata;
    if (b_mem_we) mem[b_mem_addr] <= b_mem_wdata;
    if (pl_we)    mem[pl_addr]    <= pl_dat;
  end

  // Cycles since the last clock edge that saw RESET; bit 0 is the cycle parity.
  logic [31:0] ncyc = 32'd0;
  always @(posedge CLK) ncyc <= RESET ? 32'd0 : ncyc + 32'd1;

  int n_cmp = 0;
  int n_bad = 0;
  logic [7:0] exp_q [$];

  task automatic preload(input logic [7:0] page, input int len, input bit rnd);
    logic [7:0] d;
    exp_q.delete();
    for (int i = 0; i < len; i++) begin
      @(negedge CLK);
      cpu_we = 1'b0;
      d = rnd ? 8'($urandom) : (8'(i) ^ 8'hA5);
      exp_q.push_back(d);
      pl_we = 1'b1; pl_addr = {page, 8'(i)}; pl_dat = d;
    end
    @(negedge CLK);
    pl_we = 1'b0;
  endtask

  task automatic test_reset();
    RESET = 1'b1; sel = 1'b0; cpu_we = 1'b1; cpu_addr = REG; cpu_wdata = 8'h03;
    repeat (2) @(negedge CLK);
    #1;
    n_cmp++;
    if (a_cpu_rdy !== 1'b1 || a_dma_busy !== 1'b0 || a_mem_we !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_a rdy=%b busy=%b we=%b want 1 0 0", a_cpu_rdy, a_dma_busy, a_mem_we);
    end
    n_cmp++;
    if (b_cpu_rdy !== 1'b1 || b_dma_busy !== 1'b0 || b_dma_done !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_b rdy=%b busy=%b done=%b want 1 0 0", b_cpu_rdy, b_dma_busy, b_dma_done);
    end
    RESET = 1'b0; cpu_we = 1'b0; cpu_addr = 16'h0;
    @(negedge CLK); #1;
    n_cmp++;
    if (a_cpu_rdy !== 1'b1 || a_dma_busy !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_release rdy=%b busy=%b want 1 0", a_cpu_rdy, a_dma_busy);
    end
  endtask

  task automatic test_pass_through();
    logic [7:0]  sh [0:255];
    logic [15:0] wa [0:7];
    logic [7:0]  wd;
    @(negedge CLK);
    sel = 1'b0; cpu_addr = 16'h0200; cpu_wdata = 8'h55; cpu_we = 1'b1; #1;
    n_cmp++;
    if (o_mem_addr !== 16'h0200 || o_mem_we !== 1'b1 || o_mem_wdata !== 8'h55 || o_cpu_rdy !== 1'b1) begin
      n_bad++;
      $display("FAIL pt_write addr=%h we=%b wd=%h rdy=%b want 0200 1 55 1", o_mem_addr, o_mem_we, o_mem_wdata, o_cpu_rdy);
    end
    @(negedge CLK);
    cpu_we = 1'b0; #1;
    n_cmp++;
    if (o_cpu_rdata !== 8'h55 || o_mem_we !== 1'b0) begin
      n_bad++;
      $display("FAIL pt_read rdata=%h we=%b want 55 0", o_cpu_rdata, o_mem_we);
    end
    for (int i = 0; i < 8; i++) begin
      @(negedge CLK);
      wa[i] = {8'h02, 8'($urandom)}; wd = 8'($urandom);
      cpu_addr = wa[i]; cpu_wdata = wd; cpu_we = 1'b1; #1;
      sh[wa[i][7:0]] = wd;
      n_cmp++;
      if (o_mem_addr !== wa[i] || o_mem_we !== 1'b1 || o_mem_wdata !== wd) begin
        n_bad++;
        $display("FAIL pt_rand_wr addr=%h we=%b wd=%h want %h 1 %h", o_mem_addr, o_mem_we, o_mem_wdata, wa[i], wd);
      end
    end
    for (int i = 0; i < 8; i++) begin
      @(negedge CLK);
      cpu_addr = wa[i]; cpu_we = 1'b0; #1;
      n_cmp++;
      if (o_mem_addr !== wa[i] || o_cpu_rdata !== sh[wa[i][7:0]]) begin
        n_bad++;
        $display("FAIL pt_rand_rd addr=%h rdata=%h want %h %h", o_mem_addr, o_cpu_rdata, wa[i], sh[wa[i][7:0]]);
      end
    end
  endtask

  // want: 0 = HALT on an even cycle, 1 = HALT on an odd cycle, 2 = trigger in the very next cycle.
  task automatic run_dma(input logic s, input logic [7:0] page, input int want, input int len);
    int exp_stall, off, k, ndone;
    logic p;
    @(negedge CLK);
    sel = s; cpu_we = 1'b0; cpu_addr = 16'h0;
    if (want != 2 && (~ncyc[0]) != want[0]) @(negedge CLK);
    cpu_addr = REG; cpu_wdata = page; cpu_we = 1'b1; #1;
    p = ~ncyc[0];
    off = p ? 2 : 1;
    exp_stall = off + 2 * len;
    n_cmp++;
    if (o_mem_we !== 1'b0 || o_cpu_rdy !== 1'b1 || o_dma_busy !== 1'b0) begin
      n_bad++;
      $display("FAIL trigger we=%b rdy=%b busy=%b want 0 1 0", o_mem_we, o_cpu_rdy, o_dma_busy);
    end
    ndone = 0;
    for (int c = 0; c < exp_stall; c++) begin
      @(negedge CLK);
      cpu_addr  = ($urandom_range(3) == 0) ? REG : 16'($urandom);
      cpu_wdata = 8'($urandom);
      cpu_we    = 1'($urandom);
      #1;
      if (o_dma_done === 1'b1) ndone++;
      n_cmp++;
      if (o_cpu_rdy !== 1'b0 || o_dma_busy !== 1'b1) begin
        n_bad++;
        $display("FAIL stall c=%0d rdy=%b busy=%b want 0 1", c, o_cpu_rdy, o_dma_busy);
      end
      n_cmp++;
      if (c < off) begin
        if (o_mem_we !== 1'b0 || o_mem_addr !== cpu_addr || o_dma_done !== 1'b0) begin
          n_bad++;
          $display("FAIL halt_bus c=%0d we=%b addr=%h want 0 %h", c, o_mem_we, o_mem_addr, cpu_addr);
        end
      end else begin
        k = (c - off) / 2;
        if (((c - off) % 2) == 0) begin
          if (o_mem_we !== 1'b0 || o_mem_addr !== {page, 8'(k)} || o_dma_done !== 1'b0) begin
            n_bad++;
            $display("FAIL dma_read k=%0d we=%b addr=%h want 0 %h", k, o_mem_we, o_mem_addr, {page, 8'(k)});
          end
        end else begin
          if (o_mem_we !== 1'b1 || o_mem_addr !== DST || o_mem_wdata !== exp_q[k] ||
              o_dma_done !== (k == len - 1)) begin
            n_bad++;
            $display("FAIL dma_write k=%0d we=%b addr=%h data=%h done=%b want 1 %h %h %b",
                     k, o_mem_we, o_mem_addr, o_mem_wdata, o_dma_done, DST, exp_q[k], k == len - 1);
          end
        end
      end
    end
    n_cmp++;
    if (ndone != 1) begin
      n_bad++;
      $display("FAIL done_count got=%0d want 1", ndone);
    end
  endtask

  task automatic check_idle(input string name);
    @(negedge CLK);
    cpu_we = 1'b0; cpu_addr = 16'h0; #1;
    n_cmp++;
    if (o_cpu_rdy !== 1'b1 || o_dma_busy !== 1'b0 || o_dma_done !== 1'b0) begin
      n_bad++;
      $display("FAIL %s rdy=%b busy=%b done=%b want 1 0 0", name, o_cpu_rdy, o_dma_busy, o_dma_done);
    end
  endtask

  task automatic test_even_odd_back_to_back();
    preload(8'h03, 256, 1'b0);
    run_dma(1'b0, 8'h03, 0, 256);
    run_dma(1'b0, 8'h03, 2, 256);
    run_dma(1'b0, 8'h03, 1, 256);
    check_idle("idle_after_dma");
  endtask

  task automatic test_reset_mid();
    int nw, t;
    @(negedge CLK);
    sel = 1'b0; cpu_addr = REG; cpu_wdata = 8'h03; cpu_we = 1'b1;
    nw = 0; t = 0;
    while (nw < 100 && t < 400) begin
      @(negedge CLK);
      cpu_we = 1'b0; cpu_addr = 16'h0; #1;
      if (o_mem_we === 1'b1 && o_mem_addr === DST) nw++;
      t++;
    end
    n_cmp++;
    if (nw != 100) begin
      n_bad++;
      $display("FAIL mid_timeout writes=%0d want 100", nw);
    end
    @(negedge CLK);
    RESET = 1'b1;
    @(negedge CLK);
    RESET = 1'b0; #1;
    n_cmp++;
    if (o_cpu_rdy !== 1'b1 || o_dma_busy !== 1'b0 || o_mem_we !== 1'b0 || o_dma_done !== 1'b0) begin
      n_bad++;
      $display("FAIL mid_reset rdy=%b busy=%b we=%b done=%b want 1 0 0 0", o_cpu_rdy, o_dma_busy, o_mem_we, o_dma_done);
    end
    for (int i = 0; i < 30; i++) begin
      @(negedge CLK); #1;
      n_cmp++;
      if (o_mem_we !== 1'b0 || o_dma_done !== 1'b0 || o_cpu_rdy !== 1'b1) begin
        n_bad++;
        $display("FAIL mid_quiet i=%0d we=%b done=%b rdy=%b want 0 0 1", i, o_mem_we, o_dma_done, o_cpu_rdy);
      end
    end
    run_dma(1'b0, 8'h03, 2, 256);
    check_idle("idle_after_restart");
  endtask

  task automatic test_near_miss_len16();
    @(negedge CLK);
    sel = 1'b0; cpu_addr = 16'h4015; cpu_wdata = 8'h07; cpu_we = 1'b1; #1;
    n_cmp++;
    if (o_mem_we !== 1'b1 || o_mem_addr !== 16'h4015 || o_mem_wdata !== 8'h07) begin
      n_bad++;
      $display("FAIL near_miss we=%b addr=%h wd=%h want 1 4015 07", o_mem_we, o_mem_addr, o_mem_wdata);
    end
    check_idle("near_miss_idle");
    preload(8'h05, 16, 1'b1);
    run_dma(1'b1, 8'h05, 0, 16);
    run_dma(1'b1, 8'h05, 2, 16);
    run_dma(1'b1, 8'h05, 1, 16);
    check_idle("idle_after_len16");
  endtask

  initial begin
    test_reset();
    test_pass_through();
    test_even_odd_back_to_back();
    test_reset_mid();
    test_near_miss_len16();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog compared=%0d mismatched=%0d", n_cmp, n_bad);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/cpu6502_dma_arbiter.md
Name: cpu6502_dma_arbiter

Overview:
Shares the single 6502 memory bus between the CPU and a page-copy DMA engine, in the style of NES OAM DMA.
- A CPU write to DMA_REG_ADDR latches a source page.
- The block then stalls the CPU via cpu_rdy and copies LEN bytes from {page, idx} to the fixed port DST_ADDR, one read/write pair per byte.
- It sits between the CPU core and the memory/IO decode inside cpu6502_top.

Parameters:
DMA_REG_ADDR, 16'h4014, CPU write address that triggers DMA (the written data is the source page).
DST_ADDR, 16'h2004, destination address written for every byte.
LEN, 256, bytes per transfer; power of two, 2..256.

Ports:
CLK  in  1  system clock, all state on rising edge
RESET  in  1  synchronous, active-high reset
cpu_addr  in  16  CPU bus address
cpu_wdata  in  8  CPU write data
cpu_we  in  1  CPU write enable
cpu_rdata  out  8  read data to CPU; always equals mem_rdata
cpu_rdy  out  1  1 = CPU may proceed; 0 = CPU must hold its bus
mem_addr  out  16  arbitrated memory address
mem_wdata  out  8  arbitrated write data
mem_we  out  1  arbitrated write enable
mem_rdata  in  8  memory read data, combinationally valid in the same cycle as mem_addr
dma_busy  out  1  high in every non-IDLE state
dma_done  out  1  one-cycle pulse on the final WRITE cycle

Behaviour:
Reset values:
- state=IDLE, idx=0, page=0, cyc_odd=0, data latch=0.
- cpu_rdy=1, dma_busy=0, dma_done=0, mem_we=0.

Parity:
- cyc_odd toggles every clock and is cleared by RESET.
- It is 0 in the first cycle after RESET deasserts.

IDLE:
- mem_* = cpu_* (pass-through); cpu_rdy=1.
- Trigger is cpu_we && cpu_addr==DMA_REG_ADDR. In the trigger cycle:
  - mem_we is forced to 0 (the trigger write is not forwarded);
  - page <= cpu_wdata and idx <= 0;
  - next state is HALT.

HALT (1 cycle):
- cpu_rdy=0, mem_we=0, mem_addr=cpu_addr.
- Next state is ALIGN if cyc_odd==1, else READ.

ALIGN (1 cycle):
- Dummy cycle, identical outputs to HALT.
- Next state is READ.

READ:
- mem_addr={page, idx}, mem_we=0.
- Data latch <= mem_rdata at the clock edge.
- Next state is WRITE.

WRITE:
- mem_addr=DST_ADDR, mem_wdata=latch, mem_we=1.
- If idx==LEN-1: dma_done=1, next state IDLE, idx<=0.
- Otherwise: idx<=idx+1, next state READ.

Index width and addressing:
- idx is 8 bits; only the low $clog2(LEN) bits are compared.
- Source addresses never leave the page, so there is no carry into the page byte.

Stall length:
- cpu_rdy is low in HALT, ALIGN, READ and WRITE.
- Stall is 1+2*LEN cycles (even start) or 2+2*LEN cycles (odd start): 513 or 514 for LEN=256.
- cpu_rdy returns to 1 in the IDLE cycle after the final WRITE.

CPU inputs while stalled:
- cpu_we and cpu_addr are ignored whenever cpu_rdy=0, so no re-trigger is possible during a transfer.
- A trigger in the same IDLE cycle that follows dma_done is accepted normally.

Outputs are combinational from state and registers; no extra latency on the pass-through path.

RESET mid-transfer:
- The next cycle is IDLE with cpu_rdy=1, dma_busy=0 and idx=0.
- No further DMA writes occur and there is no completion pulse.

Decomposition:
- cpu6502_pkg holds:
  - dma_state_t enum {IDLE, HALT, ALIGN, READ, WRITE}, 3-bit encoding;
  - localparams for the default DMA_REG_ADDR and DST_ADDR.
- No sub-module: the FSM, index counter, parity bit and bus mux form a single module.

Test Plan:
1. Reset: hold RESET 2 cycles with cpu_we=1, cpu_addr=16'h4014 -> cpu_rdy=1, dma_busy=0, mem_we=0; state stays IDLE after release (trigger sampled only once RESET is low).
2. Pass-through: in IDLE, CPU writes 8'h55 to 16'h0200, then reads 16'h0200 -> same-cycle mem_addr=16'h0200, mem_we=1, mem_wdata=8'h55; cpu_rdata follows mem_rdata.
3. Even-start DMA: preload 16'h0300..16'h03FF with i^8'hA5, write 8'h03 to 16'h4014 with cyc_odd=0 ->
   - trigger not forwarded;
   - cpu_rdy low for exactly 513 cycles;
   - 256 writes to 16'h2004 carrying 8'hA5, 8'hA4, ... in address order;
   - exactly one dma_done pulse, coincident with the last write.
4. Odd-start DMA: same stimulus with cyc_odd=1 -> one extra dummy cycle (stall 514); write data and order identical to scenario 3.
5. Reset mid-transfer: assert RESET after the 100th write to 16'h2004 -> next cycle cpu_rdy=1, dma_busy=0, no further writes, no dma_done; a fresh trigger with page 8'h03 then starts from source 16'h0300.
6. Near-miss and LEN=16: a write to 16'h4015 is forwarded and does not trigger; with LEN=16, page 8'h05 -> 16 writes from 16'h0500..16'h050F, stall 33 or 34 cycles.
